// File: rtl/swap_regs.sv
// Sequential register-pair exchange unit: captures two operands on start, runs a
// three-step XOR exchange (swap / pass / compare-and-swap) and presents registered results.
// Latency: 4 cycles start-to-done; throughput 1 op per 4 cycles.
// Backpressure: none; start is ignored while busy, nothing is queued.
module swap_regs #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [N-1:0] reg1,
    input  logic [N-1:0] reg2,
    output logic [N-1:0] reg1_o,
    output logic [N-1:0] reg2_o,
    output logic         busy,
    output logic         done,
    output logic         swapped
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S2   = 2'd2,
        S3   = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           x_q, x_d;
    logic [N-1:0]   r1_q, r1_d;
    logic [N-1:0]   r2_q, r2_d;
    logic           sw_q, sw_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            x_q     <= 1'b0;
            r1_q    <= '0;
            r2_q    <= '0;
            sw_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            x_q     <= x_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            sw_q    <= sw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        x_d     = x_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        sw_d    = sw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = reg1;
                    b_d     = reg2;
                    busy_d  = 1'b1;
                    state_d = S1;
                    unique case (mode)
                        2'b00:   x_d = 1'b1;
                        2'b10:   x_d = (reg1 > reg2);
                        default: x_d = 1'b0;
                    endcase
                end
            end
            S1: begin
                if (x_q) a_d = a_q ^ b_q;
                state_d = S2;
            end
            S2: begin
                if (x_q) b_d = a_q ^ b_q;
                state_d = S3;
            end
            S3: begin
                // Final XOR step lands directly in the output register.
                r1_d    = x_q ? (a_q ^ b_q) : a_q;
                r2_d    = b_q;
                sw_d    = x_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign reg1_o  = r1_q;
    assign reg2_o  = r2_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign swapped = sw_q;

endmodule

// File: tb/tb_swap_regs.sv
// Table-driven self-checking bench for swap_regs (N=8) plus hand sequences
// for reset, back-to-back start and mid-operation reset.
module tb_swap_regs;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic [7:0] reg1, reg2;
    logic [7:0] reg1_o, reg2_o;
    logic       busy, done, swapped;

    int errors = 0;
    int checks = 0;

    swap_regs #(.N(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mode    (mode),
        .reg1    (reg1),
        .reg2    (reg2),
        .reg1_o  (reg1_o),
        .reg2_o  (reg2_o),
        .busy    (busy),
        .done    (done),
        .swapped (swapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] r1;
        logic [7:0] r2;
        logic       mid_start;
        logic [1:0] mid_mode;
        logic [7:0] mid_r1;
        logic [7:0] mid_r2;
        logic [7:0] exp1;
        logic [7:0] exp2;
        logic       exp_sw;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one operation from an idle DUT and checks timing and results.
    task automatic run_op(input vec_t v, input int idx);
        int  busy_cnt;
        logic seen;
        logic extra_done;
        @(negedge clk);
        mode  = v.mode;
        reg1  = v.r1;
        reg2  = v.r2;
        start = 1'b1;
        @(negedge clk);
        start = v.mid_start;
        mode  = v.mid_mode;
        reg1  = v.mid_r1;
        reg2  = v.mid_r2;
        busy_cnt = busy ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
        end
        chk($sformatf("v%0d done_seen", idx), seen, 1);
        chk($sformatf("v%0d busy_cycles", idx), busy_cnt, 3);
        chk($sformatf("v%0d busy_at_done", idx), busy, 0);
        chk($sformatf("v%0d reg1_o", idx), reg1_o, v.exp1);
        chk($sformatf("v%0d reg2_o", idx), reg2_o, v.exp2);
        chk($sformatf("v%0d swapped", idx), swapped, v.exp_sw);
        extra_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) extra_done = 1'b1;
        end
        chk($sformatf("v%0d no_extra_done_busy", idx), extra_done, 0);
    endtask

    initial begin
        int  n;
        logic seen;
        logic bad;

        //           mode   r1     r2     mst  mmode  mr1    mr2    exp1   exp2  sw
        vecs[0] = '{2'b00, 8'd3,   8'd4,  0, 2'b00, 8'd3,  8'd4,  8'd4,  8'd3,   1};
        vecs[1] = '{2'b00, 8'd5,   8'd6,  0, 2'b01, 8'd9,  8'd10, 8'd6,  8'd5,   1};
        vecs[2] = '{2'b10, 8'd200, 8'd7,  0, 2'b10, 8'd200,8'd7,  8'd7,  8'd200, 1};
        vecs[3] = '{2'b10, 8'd7,   8'd7,  0, 2'b10, 8'd7,  8'd7,  8'd7,  8'd7,   0};
        vecs[4] = '{2'b01, 8'd5,   8'd6,  1, 2'b00, 8'd5,  8'd6,  8'd5,  8'd6,   0};
        vecs[5] = '{2'b11, 8'hAA,  8'h55, 0, 2'b11, 8'hAA, 8'h55, 8'hAA, 8'h55,  0};
        vecs[6] = '{2'b10, 8'd3,   8'd250,0, 2'b00, 8'd99, 8'd1,  8'd3,  8'd250, 0};
        vecs[7] = '{2'b00, 8'hFF,  8'h00, 0, 2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF,  1};

        // Reset held with start asserted: nothing captured, outputs stay 0.
        reset = 1'b0;
        start = 1'b1;
        mode  = 2'b00;
        reg1  = 8'd1;
        reg2  = 8'd2;
        #1;
        chk("reset_async_outputs", {reg1_o, reg2_o, busy, done, swapped}, 0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({reg1_o, reg2_o, busy, done, swapped} != 0) bad = 1'b1;
        end
        chk("reset_held_outputs", bad, 0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) run_op(vecs[i], i);

        // Start held high: second capture lands on the done edge.
        @(negedge clk);
        mode  = 2'b00;
        reg1  = 8'd1;
        reg2  = 8'd2;
        start = 1'b1;
        @(negedge clk);
        reg1 = 8'd10;
        reg2 = 8'd20;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_first_done", seen, 1);
        chk("b2b_first_reg1_o", reg1_o, 8'd2);
        chk("b2b_first_reg2_o", reg2_o, 8'd1);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_done_low", done, 0);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("b2b_second_done", seen, 1);
        chk("b2b_second_latency", n, 3);
        chk("b2b_second_reg1_o", reg1_o, 8'd20);
        chk("b2b_second_reg2_o", reg2_o, 8'd10);
        repeat (2) @(negedge clk);

        // Mid-operation reset aborts with no done.
        mode  = 2'b00;
        reg1  = 8'd1;
        reg2  = 8'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_outputs_immediate", {reg1_o, reg2_o, busy, done, swapped}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) bad = 1'b1;
        end
        chk("abort_idle_after_release", bad, 0);

        run_op(vecs[0], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/swap_regs.md
# swap_regs

Sequential N-bit register-pair exchange unit. On a start pulse it captures two operands and runs a three-step XOR exchange: unconditional swap, pass-through, or compare-and-swap by mode. It then presents the result pair on registered outputs with a one-cycle done pulse. It sits between operand registers and downstream datapath logic as a small sort and exchange primitive.

## Interface
- N, default 8, operand and result width in bits (N ≥ 1).

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request; sampled on rising edge, accepted only when idle.
- mode  input  2  operation select, captured with start: 00 swap, 01 pass, 10 compare-and-swap, 11 treated as pass.
- reg1  input  N  first operand, captured when start is accepted.
- reg2  input  N  second operand, captured when start is accepted.
- reg1_o  output  N  first result, registered.
- reg2_o  output  N  second result, registered.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when reg1_o and reg2_o are updated.
- swapped  output  1  registered flag: the last completed operation exchanged the operands.

## Operation
- Internal state: working registers A, B (N bits each), an exchange-enable bit X, and a state register.
- States are IDLE, S1, S2, S3.
- IDLE with start=1 performs the capture:
  - A<=reg1, B<=reg2, busy<=1, next state S1.
  - X is set as follows. Mode 00: X=1. Mode 10: X=(reg1 > reg2), unsigned compare. Modes 01 and 11: X=0.
- IDLE with start=0: hold all state.
- S1: if X, A<=A^B; go to S2.
- S2: if X, B<=A^B; go to S3.
- S3 (completion):
  - reg1_o <= (X ? A^B : A), reg2_o <= B, swapped <= X.
  - done <= 1, busy <= 0, next state IDLE.
- done is driven low in every cycle other than the one following S3.
- start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- Mode 10 yields reg1_o = min(reg1, reg2) and reg2_o = max(reg1, reg2). Equal operands are not swapped, so swapped=0.
- Operands are sampled once at capture. Changes on reg1, reg2 or mode during busy have no effect.
- Results hold until the next completed operation. No combinational path from inputs to outputs.

## Timing
- Reset (reset=0) acts immediately, without waiting for a clock edge:
  - reg1_o=0, reg2_o=0, busy=0, done=0, swapped=0.
  - A=0, B=0, X=0, state=IDLE.
- Reset asserted mid-operation aborts it. No done pulse is produced and outputs go to 0.
- First accepting edge after reset deasserts: the first rising edge with reset=1 and start=1.
- Latency, with start accepted on edge k:
  - busy=1 after edges k, k+1 and k+2.
  - Results valid, done=1 and busy=0 after edge k+3.
  - done drops after edge k+4 unless a new completion occurs there, which is impossible.
- Back-to-back: start may be asserted in the cycle done=1, because the state is IDLE. That capture is accepted on edge k+4.
- Throughput is one operation per 4 cycles.
- A start pulse held high is accepted again at every IDLE edge.

## Test plan
- Reset check: hold reset=0 with reg1=1, reg2=2, start=1 -> reg1_o=0, reg2_o=0, busy=0, done=0 throughout, with no capture.
- Swap: release reset, mode=00, reg1=3, reg2=4, start for 1 cycle -> 3 edges later reg1_o=4, reg2_o=3, swapped=1, done high for exactly 1 cycle, busy high for exactly 3 cycles.
- Input change during busy: start mode=00 with reg1=5, reg2=6, then change inputs to 9/10 one cycle later -> results reg1_o=6, reg2_o=5.
- Compare-and-swap, two runs:
  - mode=10, reg1=200, reg2=7 -> reg1_o=7, reg2_o=200, swapped=1.
  - Then reg1=7, reg2=7 -> reg1_o=7, reg2_o=7, swapped=0.
- Pass and ignored start: mode=01, reg1=5, reg2=6 -> reg1_o=5, reg2_o=6, swapped=0. A start pulse asserted during busy produces no extra done.
- Mid-operation reset: accept a swap of 1/2, assert reset=0 one edge later -> outputs 0 immediately, no done, IDLE after release.
